// File: rtl/multi_stage_output_channel_credit_tracker_if.sv
// ---------------------------------------------------------------------------
// multi_stage_output_channel_credit_tracker_if
// Bundle between the issue/commit front end and the output channel credit
// tracker.
//   output_channel_counts : committed occupancy per channel
//   issue_valid/issue_oci : instruction issued, channels it will write
//   commit_valid/commit_oci : instruction committed, channels written
//   flush                 : squash everything in flight
//   output_channel_full   : channel cannot take another issued write
//   inflight_counts       : registered in-flight count per channel
//   credit_error          : sticky saturate/underflow flag
//                           (present only with TIA_CREDIT_TRACKER_ERROR_EN)
// master = front end / testbench, slave = tracker.
// ---------------------------------------------------------------------------
interface multi_stage_output_channel_credit_tracker_if #(
   parameter int NUM_CHANNELS = 4,
   parameter int COUNT_WIDTH  = 2,
   parameter int IF_WIDTH     = 2
);
   logic [NUM_CHANNELS-1:0][COUNT_WIDTH-1:0] output_channel_counts;
   logic                                     issue_valid;
   logic [NUM_CHANNELS-1:0]                  issue_oci;
   logic                                     commit_valid;
   logic [NUM_CHANNELS-1:0]                  commit_oci;
   logic                                     flush;
   logic [NUM_CHANNELS-1:0]                  output_channel_full;
   logic [NUM_CHANNELS-1:0][IF_WIDTH-1:0]    inflight_counts;
`ifdef TIA_CREDIT_TRACKER_ERROR_EN
   logic                                     credit_error;
`endif

   modport master (
`ifdef TIA_CREDIT_TRACKER_ERROR_EN
      input  credit_error,
`endif
      output output_channel_counts, issue_valid, issue_oci,
             commit_valid, commit_oci, flush,
      input  output_channel_full, inflight_counts
   );

   modport slave (
`ifdef TIA_CREDIT_TRACKER_ERROR_EN
      output credit_error,
`endif
      input  output_channel_counts, issue_valid, issue_oci,
             commit_valid, commit_oci, flush,
      output output_channel_full, inflight_counts
   );
endinterface

// File: rtl/multi_stage_output_channel_credit_tracker.sv
// ---------------------------------------------------------------------------
// multi_stage_output_channel_credit_tracker
// Counts, per output channel, the instructions issued but not yet committed
// that will write that channel, and flags a channel full when committed
// occupancy plus in-flight writes reaches the buffer depth.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-high reset (clears all counters)
//   bus   : multi_stage_output_channel_credit_tracker_if.slave
// Optional feature: define TIA_CREDIT_TRACKER_ERROR_EN to add the sticky
// bus.credit_error output (set on any saturate-at-max or decrement-at-zero).
// ---------------------------------------------------------------------------

// One channel: saturating in-flight counter plus full compare.
module msoc_credit_lane #(
   parameter int NUM_STAGES  = 3,
   parameter int FIFO_DEPTH  = 2,
   parameter int COUNT_WIDTH = 2,
   parameter int IF_WIDTH    = 2,
   parameter int SUM_WIDTH   = 3
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   inc,
   input  logic                   dec,
   input  logic                   flush,
   input  logic [COUNT_WIDTH-1:0] count,
   output logic [IF_WIDTH-1:0]    cnt,
   output logic                   full
);
   localparam logic [IF_WIDTH-1:0] MAX_CNT = IF_WIDTH'(NUM_STAGES);

   logic [IF_WIDTH-1:0]  cnt_nxt;
   logic [SUM_WIDTH-1:0] sum;

   // issue and commit together cancel; flush wins over both
   always_comb begin
      cnt_nxt = cnt;
      if (flush)
         cnt_nxt = '0;
      else if (inc && !dec && cnt != MAX_CNT)
         cnt_nxt = cnt + IF_WIDTH'(1);
      else if (dec && !inc && cnt != '0)
         cnt_nxt = cnt - IF_WIDTH'(1);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) cnt <= '0;
      else       cnt <= cnt_nxt;
   end

   // one bit wider than the wider operand, so the add cannot wrap
   assign sum  = SUM_WIDTH'(count) + SUM_WIDTH'(cnt);
   assign full = (32'(sum) >= FIFO_DEPTH);
endmodule

module multi_stage_output_channel_credit_tracker #(
   parameter int NUM_CHANNELS = 4,
   parameter int FIFO_DEPTH   = 2,
   parameter int COUNT_WIDTH  = 2,
   parameter int NUM_STAGES   = 3
) (
   input  logic clock,
   input  logic reset,
   multi_stage_output_channel_credit_tracker_if.slave bus
);
   localparam int IF_WIDTH  = $clog2(NUM_STAGES + 1);
   localparam int SUM_WIDTH = ((COUNT_WIDTH > IF_WIDTH) ? COUNT_WIDTH : IF_WIDTH) + 1;

   // masks are qualified by their valids here so lanes never see stale oci
   logic [NUM_CHANNELS-1:0] inc, dec;
   assign inc = {NUM_CHANNELS{bus.issue_valid}}  & bus.issue_oci;
   assign dec = {NUM_CHANNELS{bus.commit_valid}} & bus.commit_oci;

   for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_lane
      msoc_credit_lane #(
         .NUM_STAGES  (NUM_STAGES),
         .FIFO_DEPTH  (FIFO_DEPTH),
         .COUNT_WIDTH (COUNT_WIDTH),
         .IF_WIDTH    (IF_WIDTH),
         .SUM_WIDTH   (SUM_WIDTH)
      ) u_lane (
         .clock (clock),
         .reset (reset),
         .inc   (inc[i]),
         .dec   (dec[i]),
         .flush (bus.flush),
         .count (bus.output_channel_counts[i]),
         .cnt   (bus.inflight_counts[i]),
         .full  (bus.output_channel_full[i])
      );
   end

`ifdef TIA_CREDIT_TRACKER_ERROR_EN
   localparam logic [IF_WIDTH-1:0] MAX_CNT = IF_WIDTH'(NUM_STAGES);

   // a clamped update is an accounting error; a flush edge never is
   logic [NUM_CHANNELS-1:0] err_hit;
   always_comb begin
      err_hit = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         err_hit[i] = !bus.flush &&
                      ((inc[i] && !dec[i] && bus.inflight_counts[i] == MAX_CNT) ||
                       (dec[i] && !inc[i] && bus.inflight_counts[i] == '0));
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)         bus.credit_error <= 1'b0;
      else if (|err_hit) bus.credit_error <= 1'b1;
   end
`endif
endmodule

// File: tb/tb_multi_stage_output_channel_credit_tracker.sv
// ---------------------------------------------------------------------------
// tb_multi_stage_output_channel_credit_tracker
// Directed bench: default-parameter tracker plus an 8-channel instance.
// Expected inflight/full values are queued with each stimulus step and
// popped/compared after the DUT responds.
// ---------------------------------------------------------------------------
module tb_multi_stage_output_channel_credit_tracker;
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   multi_stage_output_channel_credit_tracker_if #(.NUM_CHANNELS(4), .COUNT_WIDTH(2), .IF_WIDTH(2)) bus ();
   multi_stage_output_channel_credit_tracker_if #(.NUM_CHANNELS(8), .COUNT_WIDTH(3), .IF_WIDTH(2)) bus2 ();

   multi_stage_output_channel_credit_tracker #(
      .NUM_CHANNELS(4), .FIFO_DEPTH(2), .COUNT_WIDTH(2), .NUM_STAGES(3)
   ) dut (.clock(clock), .reset(reset), .bus(bus));

   multi_stage_output_channel_credit_tracker #(
      .NUM_CHANNELS(8), .FIFO_DEPTH(4), .COUNT_WIDTH(3), .NUM_STAGES(3)
   ) dut2 (.clock(clock), .reset(reset), .bus(bus2));

   typedef struct {
      string       tag;
      bit          sel2;
      logic [15:0] ifl;
      logic [7:0]  full;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int errors = 0;

   task automatic exp1(input string tag, input logic [7:0] ifl, input logic [3:0] full);
      exp_t e;
      e.tag = tag; e.sel2 = 1'b0; e.ifl = {8'h00, ifl}; e.full = {4'h0, full};
      sb.push_back(e);
   endtask

   task automatic exp2(input string tag, input logic [15:0] ifl, input logic [7:0] full);
      exp_t e;
      e.tag = tag; e.sel2 = 1'b1; e.ifl = ifl; e.full = full;
      sb.push_back(e);
   endtask

   task automatic chk();
      exp_t e;
      logic [15:0] ifl;
      logic [7:0]  fl;
      checks++;
      assert (sb.size() != 0) else begin
         errors++;
         $error("FAIL sb_empty observed 0 entries expected at least 1");
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         if (e.sel2) begin
            ifl = bus2.inflight_counts;
            fl  = bus2.output_channel_full;
         end else begin
            ifl = {8'h00, bus.inflight_counts};
            fl  = {4'h0, bus.output_channel_full};
         end
         checks++;
         assert (ifl === e.ifl) else begin
            errors++;
            $error("FAIL %s inflight observed %h expected %h", e.tag, ifl, e.ifl);
         end
         checks++;
         assert (fl === e.full) else begin
            errors++;
            $error("FAIL %s full observed %b expected %b", e.tag, fl, e.full);
         end
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      chk();
   endtask

`ifdef TIA_CREDIT_TRACKER_ERROR_EN
   task automatic chk_err(input string tag, input logic want);
      checks++;
      assert (bus.credit_error === want) else begin
         errors++;
         $error("FAIL %s credit_error observed %b expected %b", tag, bus.credit_error, want);
      end
   endtask
`endif

   initial begin
      bus.output_channel_counts = '0; bus.issue_valid = 0; bus.issue_oci = '0;
      bus.commit_valid = 0; bus.commit_oci = '0; bus.flush = 0;
      bus2.output_channel_counts = '0; bus2.issue_valid = 0; bus2.issue_oci = '0;
      bus2.commit_valid = 0; bus2.commit_oci = '0; bus2.flush = 0;

      // reset state, and full tracks counts alone while reset is held
      #2; exp1("rst", 8'h00, 4'b0000); chk();
`ifdef TIA_CREDIT_TRACKER_ERROR_EN
      chk_err("rst_err", 1'b0);
`endif
      bus.output_channel_counts[0] = 2'd2;
      #1; exp1("rst_full", 8'h00, 4'b0001); chk();
      bus.output_channel_counts = '0;
      @(negedge clock); reset = 1'b0;

      // two issues to ch0: full only after the second edge
      bus.issue_valid = 1; bus.issue_oci = 4'b0001;
      exp1("iss1", 8'h01, 4'b0000); step();
      exp1("iss2", 8'h02, 4'b0001); step();

      // commits drain ch0; issue_oci ignored while issue_valid is low
      bus.issue_valid = 0; bus.issue_oci = 4'b1111;
      bus.commit_valid = 1; bus.commit_oci = 4'b0001;
      exp1("cmt1", 8'h01, 4'b0000); step();
      exp1("cmt2", 8'h00, 4'b0000); step();

      // ch1: issue, then simultaneous issue+commit holds
      bus.commit_valid = 0; bus.commit_oci = 4'b1111;
      bus.issue_valid = 1; bus.issue_oci = 4'b0010;
      exp1("iss_c1", 8'h04, 4'b0000); step();
      bus.commit_valid = 1; bus.commit_oci = 4'b0010;
      exp1("iss_cmt_same", 8'h04, 4'b0000); step();
      bus.issue_valid = 0; bus.commit_valid = 0;
      bus.output_channel_counts[1] = 2'd1;
      #1; exp1("cnt_zero_lat", 8'h04, 4'b0010); chk();
      bus.output_channel_counts = '0;

      // build 3,2,1,0 then flush over an all-channel issue
      bus.issue_valid = 1; bus.issue_oci = 4'b0001;
      exp1("b1", 8'h05, 4'b0000); step();
      bus.issue_oci = 4'b0011;
      exp1("b2", 8'h0A, 4'b0011); step();
      bus.issue_oci = 4'b0101;
      exp1("b3", 8'h1B, 4'b0011); step();
      bus.flush = 1; bus.issue_oci = 4'b1111;
      bus.commit_valid = 1; bus.commit_oci = 4'b0001;
      exp1("flush", 8'h00, 4'b0000); step();
      bus.flush = 0; bus.commit_valid = 0;

      // saturate ch2 at 3, then underflow attempt on ch3
      bus.issue_oci = 4'b0100;
      exp1("sat1", 8'h10, 4'b0000); step();
      exp1("sat2", 8'h20, 4'b0100); step();
      exp1("sat3", 8'h30, 4'b0100); step();
`ifdef TIA_CREDIT_TRACKER_ERROR_EN
      chk_err("no_err_yet", 1'b0);
`endif
      exp1("sat_hold", 8'h30, 4'b0100); step();
`ifdef TIA_CREDIT_TRACKER_ERROR_EN
      chk_err("sat_err", 1'b1);
`endif
      bus.issue_valid = 0;
      bus.commit_valid = 1; bus.commit_oci = 4'b1000;
      exp1("udf_hold", 8'h30, 4'b0100); step();
      bus.commit_valid = 0;

      // async reset mid-cycle
      bus.flush = 1;
      exp1("flush2", 8'h00, 4'b0000); step();
      bus.flush = 0; bus.issue_valid = 1; bus.issue_oci = 4'b0001;
      exp1("r1", 8'h01, 4'b0000); step();
      exp1("r2", 8'h02, 4'b0001); step();
      bus.issue_valid = 0;
      #3; reset = 1'b1;
      #1; exp1("async_rst", 8'h00, 4'b0000); chk();
`ifdef TIA_CREDIT_TRACKER_ERROR_EN
      chk_err("rst_clr_err", 1'b0);
`endif

      // first edge after release acts normally
      bus.issue_valid = 1; bus.issue_oci = 4'b0010;
      @(negedge clock); reset = 1'b0;
      exp1("post_rst", 8'h04, 4'b0000); step();
      bus.issue_valid = 0;

      // 8-channel, depth 4, 3-bit counts
      bus2.output_channel_counts[7] = 3'd3;
      #1; exp2("d2_pre", 16'h0000, 8'h00); chk();
      bus2.issue_valid = 1; bus2.issue_oci = 8'h80;
      exp2("d2_iss", 16'h4000, 8'h80); step();
      bus2.issue_valid = 0;
      bus2.output_channel_counts[7] = 3'd2;
      #1; exp2("d2_drop", 16'h4000, 8'h00); chk();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
